booth_mult_arbiter: RTL and testbench
=====================================

Name: booth_mult_arbiter

Overview:
Round-robin arbiter and sequencer that shares one modified_booth_multiplier_sync instance among NUM_REQ independent requesters.
- Accepts signed 8-bit operand pairs over per-requester valid/ready handshakes.
- Issues at most one operation per cycle to the shared multiplier.
- Tracks in-flight operations through a tag pipeline matched to the multiplier latency.
- Returns each 16-bit product to its originating requester through a one-entry response buffer.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
MUL_LAT, 1, multiplier latency in clock edges from operands valid at its input to product valid at its output.
ID_W, 2, requester-index width; must satisfy 2**ID_W >= NUM_REQ.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous, active-low reset.
req_valid  input  NUM_REQ  per-requester request valid.
req_ready  output  NUM_REQ  per-requester request accept (grant).
req_a  input  8*NUM_REQ  signed multiplicands, requester i at [8i+7:8i].
req_b  input  8*NUM_REQ  signed multipliers, requester i at [8i+7:8i].
rsp_valid  output  NUM_REQ  per-requester product valid.
rsp_ready  input  NUM_REQ  per-requester product consume.
rsp_product  output  16*NUM_REQ  signed products, requester i at [16i+15:16i].
mul_a  output  8  registered multiplicand to the shared multiplier.
mul_b  output  8  registered multiplier operand to the shared multiplier.
mul_p  input  16  product from the shared multiplier.
idle  output  1  high when no requester is busy.

Behaviour:
Reset (rst_n low at a rising edge):
- busy, rsp_valid, tag pipeline valids, mul_a, mul_b and all rsp_product fields clear to 0.
- Round-robin pointer resets to 0; idle resets to 1.
- A reset mid-operation drops all in-flight results silently.

Eligibility and grant:
- Requester i is eligible when req_valid[i]=1 and busy[i]=0.
- busy[i] sets on a grant and clears on the rsp_valid[i] && rsp_ready[i] edge.
- Each requester therefore has at most one outstanding operation.
- Grant is combinational. The winner is the first eligible index scanning upward from the pointer, with wrap-around.
- req_ready is one-hot or zero; req_ready[i] = grant[i]; handshake is req_valid && req_ready.
- On a grant edge, the pointer moves to winner+1 mod NUM_REQ. With no grant, the pointer holds.
- req_ready must never assert for a busy requester, even when req_valid is high.

Issue stage:
- On a grant edge: mul_a <= winner's req_a, mul_b <= winner's req_b, tag stage 0 <= {1, winner id}.
- With no grant: mul_a and mul_b are driven to 0 and the tag-0 valid bit is 0.
- Tag pipeline depth is MUL_LAT, advancing every cycle.

Completion:
- When the last tag stage is valid, mul_p is captured into rsp_product[id] and rsp_valid[id] sets.
- Capture happens at the same edge the tag leaves the pipeline.

Latency:
- rsp_valid[i] rises MUL_LAT+1 edges after the accepting edge. For MUL_LAT=1, it is visible 2 cycles after acceptance.
- Throughput is one operation per cycle across different requesters.

Response buffer:
- rsp_product[i] is stable while rsp_valid[i]=1.
- rsp_valid[i] clears on the rsp_valid[i] && rsp_ready[i] edge.
- Requester i becomes eligible again the cycle after that edge; no same-edge re-grant.
- Overwrite cannot occur because only one operation per requester is outstanding.

Simultaneous events:
- A grant to requester j and a completion for requester k≠j in the same cycle are independent.
- A response consume and a completion for the same requester cannot coincide, because busy prevents it.

Arithmetic:
- No arithmetic in this block. Products pass through bit-exact, two's complement 16-bit.

idle = ~|busy, registered alongside busy.

Decomposition:
- Shared package booth_mult_pkg holds:
  - constants OPND_W=8 and PROD_W=16;
  - the tag struct {valid, id};
  - a round-robin helper function returning the winner index from an eligible mask and the pointer.
- One natural sub-module, rr_arbiter (eligible mask + pointer -> one-hot grant, next pointer).
- The multiplier stays external. The bench connects mul_a, mul_b and mul_p to modified_booth_multiplier_sync.

Test Plan:
1. Single request: req0 a=27, b=-15 (0xF1) -> req_ready[0] same cycle; rsp_valid[0] 2 cycles later with rsp_product[15:0]=0xFE6B (-405); idle returns to 1 after rsp_ready.
2. Four simultaneous requests: (10,10), (-10,10), (-128,-128), (-128,10), pointer=0:
   - grants go to 0, 1, 2, 3 on consecutive cycles;
   - products are 0x0064, 0xFF9C, 0x4000, 0xFB00;
   - each rsp_valid is 2 cycles after its grant.
3. Fairness: req0 and req1 held valid continuously, rsp_ready=1 -> grants alternate, with neither starved beyond NUM_REQ cycles.
4. Backpressure: req2 result held with rsp_ready[2]=0 for 10 cycles while req_valid[2] stays high -> req_ready[2] stays 0; rsp_product[2] stays stable; other requesters are still served.
5. Reset mid-operation: assert rst_n=0 one cycle after a grant -> no rsp_valid ever appears for that operation; all outputs are 0; idle=1; pointer=0.
6. Boundary: -128 * 127 -> 0xC080 (-16256). Also run with MUL_LAT=2 and a delayed multiplier model -> rsp_valid at 3 cycles after the grant.

Source files
------------

// File: rtl/booth_mult_pkg.sv
// Shared definitions for the booth multiplier arbiter slice.
//   OPND_W / PROD_W : operand and product widths of the shared multiplier
//   tag_t           : in-flight tag {valid, requester id}
//   rr_pick         : round-robin winner search over an eligible mask
package booth_mult_pkg;

    localparam int OPND_W   = 8;
    localparam int PROD_W   = 16;
    localparam int MAX_REQ  = 8;
    localparam int TAG_ID_W = 3;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

    // Returns {found, index}. Scans n requesters starting at ptr with
    // wrap-around. The loop runs from the largest offset downward so the
    // smallest offset from ptr is the last one written and therefore wins.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0]  elig,
                                           input logic [TAG_ID_W-1:0] ptr,
                                           input logic [3:0]          n);
        logic [3:0] idx;
        logic [3:0] res;
        res = '0;
        for (int k = MAX_REQ - 1; k >= 0; k--) begin
            if (4'(k) < n) begin
                idx = {1'b0, ptr} + 4'(k);
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (elig[idx[2:0]]) begin
                    res = {1'b1, idx[2:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   eligible  : requesters that may be granted this cycle
//   ptr       : highest-priority index for this cycle
//   grant     : one-hot grant (or zero)
//   winner    : index of the granted requester (valid when grant_any)
//   grant_any : some requester was granted
//   next_ptr  : winner+1 modulo NUM_REQ
module rr_arbiter
    import booth_mult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               grant_any,
    output logic [ID_W-1:0]    next_ptr
);

    logic [3:0] pick;

    always_comb begin
        pick      = rr_pick(MAX_REQ'(eligible), TAG_ID_W'(ptr), 4'(NUM_REQ));
        grant_any = pick[3];
        winner    = ID_W'(pick[2:0]);
        grant     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = grant_any && (winner == ID_W'(i));
        end
        if (int'(winner) == NUM_REQ - 1) begin
            next_ptr = '0;
        end else begin
            next_ptr = winner + ID_W'(1);
        end
    end

endmodule

// File: rtl/booth_mult_arbiter.sv
// Shares one external multiplier among NUM_REQ requesters.
// Each requester hands over a signed operand pair with req_valid/req_ready,
// the winner's operands are registered onto mul_a/mul_b, a tag follows the
// operation through the multiplier latency, and the product lands in a
// one-entry per-requester response buffer (rsp_valid/rsp_ready).
//   clk, rst_n           : clock, synchronous active-low reset
//   req_valid/req_ready  : per-requester request handshake
//   req_a, req_b         : packed 8-bit signed operands per requester
//   rsp_valid/rsp_ready  : per-requester response handshake
//   rsp_product          : packed 16-bit signed products per requester
//   mul_a, mul_b, mul_p  : shared multiplier interface
//   idle                 : no requester has an outstanding operation
module booth_mult_arbiter
    import booth_mult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MUL_LAT = 1,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [OPND_W*NUM_REQ-1:0] req_a,
    input  logic [OPND_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [PROD_W*NUM_REQ-1:0] rsp_product,
    output logic [OPND_W-1:0]         mul_a,
    output logic [OPND_W-1:0]         mul_b,
    input  logic [PROD_W-1:0]         mul_p,
    output logic                      idle
);

    logic [NUM_REQ-1:0]        busy;
    logic [NUM_REQ-1:0]        busy_next;
    logic [NUM_REQ-1:0]        eligible;
    logic [NUM_REQ-1:0]        grant;
    logic [NUM_REQ-1:0]        rsp_fire;
    logic [NUM_REQ-1:0]        done_mask;
    logic [NUM_REQ-1:0]        rsp_valid_q;
    logic [PROD_W*NUM_REQ-1:0] rsp_product_q;
    logic [ID_W-1:0]           ptr;
    logic [ID_W-1:0]           next_ptr;
    logic [ID_W-1:0]           winner;
    logic                      grant_any;
    logic [OPND_W-1:0]         win_a;
    logic [OPND_W-1:0]         win_b;
    logic [OPND_W-1:0]         mul_a_q;
    logic [OPND_W-1:0]         mul_b_q;
    logic                      idle_q;
    tag_t                      tag_in;
    tag_t                      tag_last;

    // Stage 0 is loaded together with mul_a/mul_b; stages 1..MUL_LAT track
    // the multiplier's own latency, so the tag reaches the end exactly when
    // mul_p holds the matching product.
    tag_t tag_q [0:MUL_LAT];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .eligible  (eligible),
        .ptr       (ptr),
        .grant     (grant),
        .winner    (winner),
        .grant_any (grant_any),
        .next_ptr  (next_ptr)
    );

    always_comb begin
        eligible = req_valid & ~busy;
        rsp_fire = rsp_valid_q & rsp_ready;
        // A requester is never granted while busy, and only busy requesters
        // can consume, so set and clear never target the same bit.
        busy_next = (busy | grant) & ~rsp_fire;

        win_a = req_a[int'(winner)*OPND_W +: OPND_W];
        win_b = req_b[int'(winner)*OPND_W +: OPND_W];

        tag_in = '0;
        if (grant_any) begin
            tag_in.valid = 1'b1;
            tag_in.id    = TAG_ID_W'(winner);
        end

        tag_last  = tag_q[MUL_LAT];
        done_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            done_mask[i] = tag_last.valid && (tag_last.id == TAG_ID_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy          <= '0;
            rsp_valid_q   <= '0;
            rsp_product_q <= '0;
            ptr           <= '0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            idle_q        <= 1'b1;
            for (int s = 0; s <= MUL_LAT; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            busy        <= busy_next;
            idle_q      <= ~|busy_next;
            rsp_valid_q <= (rsp_valid_q & ~rsp_fire) | done_mask;
            if (grant_any) begin
                ptr <= next_ptr;
            end
            mul_a_q  <= grant_any ? win_a : '0;
            mul_b_q  <= grant_any ? win_b : '0;
            tag_q[0] <= tag_in;
            for (int s = 1; s <= MUL_LAT; s++) begin
                tag_q[s] <= tag_q[s-1];
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (done_mask[i]) begin
                    rsp_product_q[i*PROD_W +: PROD_W] <= mul_p;
                end
            end
        end
    end

    assign req_ready   = grant;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_product = rsp_product_q;
    assign mul_a       = mul_a_q;
    assign mul_b       = mul_b_q;
    assign idle        = idle_q;

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter: one instance with MUL_LAT=1 and one
// with MUL_LAT=2, each fed by a behavioural registered multiplier model.
module tb_booth_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0] req_a, req_b;
    logic [63:0] rsp_product;
    logic [7:0]  mul_a, mul_b;
    logic [15:0] mul_p;
    logic        idle;

    logic [3:0]  req_valid_l2, req_ready_l2, rsp_valid_l2, rsp_ready_l2;
    logic [31:0] req_a_l2, req_b_l2;
    logic [63:0] rsp_product_l2;
    logic [7:0]  mul_a_l2, mul_b_l2;
    logic [15:0] mul_p_l2, mul_p_l2_s1;
    logic        idle_l2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    booth_mult_arbiter #(.NUM_REQ(4), .MUL_LAT(1), .ID_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_product(rsp_product),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .idle(idle)
    );

    booth_mult_arbiter #(.NUM_REQ(4), .MUL_LAT(2), .ID_W(2)) dut_l2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_l2), .req_ready(req_ready_l2),
        .req_a(req_a_l2), .req_b(req_b_l2),
        .rsp_valid(rsp_valid_l2), .rsp_ready(rsp_ready_l2),
        .rsp_product(rsp_product_l2),
        .mul_a(mul_a_l2), .mul_b(mul_b_l2), .mul_p(mul_p_l2),
        .idle(idle_l2)
    );

    // Shared multiplier models: one and two registered stages.
    always_ff @(posedge clk) begin
        mul_p       <= 16'($signed(mul_a) * $signed(mul_b));
        mul_p_l2_s1 <= 16'($signed(mul_a_l2) * $signed(mul_b_l2));
        mul_p_l2    <= mul_p_l2_s1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        req_valid    = '0; req_a    = '0; req_b    = '0; rsp_ready    = '0;
        req_valid_l2 = '0; req_a_l2 = '0; req_b_l2 = '0; rsp_ready_l2 = '0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
        req_valid[i]    = 1'b1;
    endtask

    logic [3:0] exp_mask;
    logic [3:0] fair_exp [12];

    initial begin
        do_reset();

        // reset state
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h0);
        check("rst_mul_a", 64'(mul_a), 64'h0);
        check("rst_mul_b", 64'(mul_b), 64'h0);
        check("rst_product", rsp_product, 64'h0);
        check("rst_idle", 64'(idle), 64'h1);

        // 1: single request 27 * -15
        set_req(0, 8'd27, 8'hF1);
        #1;
        check("t1_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        check("t1_mul_a", 64'(mul_a), 64'h1B);
        check("t1_mul_b", 64'(mul_b), 64'hF1);
        check("t1_idle_busy", 64'(idle), 64'h0);
        check("t1_rsp_early0", 64'(rsp_valid), 64'h0);
        tick();
        check("t1_rsp_early1", 64'(rsp_valid), 64'h0);
        tick();
        check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t1_product", 64'(rsp_product[15:0]), 64'hFE6B);
        rsp_ready = 4'b0001;
        tick();
        rsp_ready = '0;
        check("t1_rsp_clear", 64'(rsp_valid), 64'h0);
        check("t1_idle_back", 64'(idle), 64'h1);

        // 2: four simultaneous requests from pointer 0
        do_reset();
        set_req(0, 8'd10, 8'd10);
        set_req(1, 8'hF6, 8'd10);
        set_req(2, 8'h80, 8'h80);
        set_req(3, 8'h80, 8'd10);
        for (int e = 0; e < 6; e++) begin
            if (e < 4) begin
                #1;
                check($sformatf("t2_ready_%0d", e), 64'(req_ready), 64'(4'b0001 << e));
            end
            tick();
            if (e < 4) req_valid[e] = 1'b0;
            exp_mask = '0;
            for (int j = 0; j < 4; j++) begin
                if (j + 2 <= e) exp_mask[j] = 1'b1;
            end
            check($sformatf("t2_rsp_valid_%0d", e), 64'(rsp_valid), 64'(exp_mask));
        end
        check("t2_p0", 64'(rsp_product[15:0]),  64'h0064);
        check("t2_p1", 64'(rsp_product[31:16]), 64'hFF9C);
        check("t2_p2", 64'(rsp_product[47:32]), 64'h4000);
        check("t2_p3", 64'(rsp_product[63:48]), 64'hFB00);
        rsp_ready = 4'b1111;
        tick();
        rsp_ready = '0;
        check("t2_drained", 64'(rsp_valid), 64'h0);
        check("t2_idle", 64'(idle), 64'h1);

        // 3: fairness between two continuously valid requesters
        do_reset();
        fair_exp = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0};
        set_req(0, 8'd3, 8'hFC);
        set_req(1, 8'hF9, 8'hF9);
        rsp_ready = 4'b1111;
        for (int c = 0; c < 12; c++) begin
            #1;
            check($sformatf("t3_grant_%0d", c), 64'(req_ready), 64'(fair_exp[c]));
            tick();
        end
        req_valid = '0;
        for (int c = 0; c < 4; c++) tick();
        check("t3_idle", 64'(idle), 64'h1);
        rsp_ready = '0;

        // 4: backpressure on requester 2, boundary -128 * 127
        do_reset();
        rsp_ready = 4'b1011;
        set_req(2, 8'h80, 8'h7F);
        #1;
        check("t4_ready2", 64'(req_ready), 64'h4);
        tick();
        tick();
        tick();
        check("t4_rsp_valid", 64'(rsp_valid), 64'h4);
        check("t4_product", 64'(rsp_product[47:32]), 64'hC080);
        set_req(0, 8'd5, 8'hFA);
        #1;
        check("t4_other_served", 64'(req_ready), 64'h1);
        tick();
        req_valid[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t4_blocked_%0d", i), 64'(req_ready), 64'h0);
            check($sformatf("t4_stable_%0d", i), 64'(rsp_product[47:32]), 64'hC080);
            if (i == 1) begin
                check("t4_rsp_both", 64'(rsp_valid), 64'h5);
                check("t4_p0", 64'(rsp_product[15:0]), 64'hFFE2);
            end
        end
        rsp_ready[2] = 1'b1;
        #1;
        check("t4_no_same_edge", 64'(req_ready), 64'h0);
        tick();
        check("t4_consumed", 64'(rsp_valid), 64'h0);
        check("t4_regrant", 64'(req_ready), 64'h4);
        req_valid = '0;
        rsp_ready = '0;

        // 5: reset one cycle after a grant
        do_reset();
        set_req(1, 8'd9, 8'd9);
        #1;
        check("t5_ready1", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_rsp_valid", 64'(rsp_valid), 64'h0);
        check("t5_mul_a", 64'(mul_a), 64'h0);
        check("t5_mul_b", 64'(mul_b), 64'h0);
        check("t5_product", rsp_product, 64'h0);
        check("t5_idle", 64'(idle), 64'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("t5_no_rsp_%0d", i), 64'(rsp_valid), 64'h0);
        end
        req_valid = 4'b1110;
        #1;
        check("t5_ptr_zero", 64'(req_ready), 64'h2);
        req_valid = '0;

        // 6: MUL_LAT=2 instance, -128 * 127 on requester 3
        req_a_l2[31:24] = 8'h80;
        req_b_l2[31:24] = 8'h7F;
        req_valid_l2    = 4'b1000;
        #1;
        check("t6_ready3", 64'(req_ready_l2), 64'h8);
        tick();
        req_valid_l2 = '0;
        tick();
        check("t6_early1", 64'(rsp_valid_l2), 64'h0);
        tick();
        check("t6_early2", 64'(rsp_valid_l2), 64'h0);
        tick();
        check("t6_rsp_valid", 64'(rsp_valid_l2), 64'h8);
        check("t6_product", 64'(rsp_product_l2[63:48]), 64'hC080);
        rsp_ready_l2 = 4'b1000;
        tick();
        rsp_ready_l2 = '0;
        check("t6_idle", 64'(idle_l2), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
